// File: rtl/mini_proc_pkg.sv
// mini_proc_pkg: shared command/state encodings and saturation limits
package mini_proc_pkg;
  typedef enum logic [2:0] {
    CMD_LDI, CMD_RD1, CMD_RD2, CMD_ADDI, CMD_ADD, CMD_SUB, CMD_SLLV, CMD_SRAI
  } cmd_e;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;
  localparam int MAX_DW = 64;
  function automatic logic [MAX_DW-1:0] sat_max(input int dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction
  function automatic logic [MAX_DW-1:0] sat_min(input int dw);
    return 64'd1 << (dw - 1);
  endfunction
endpackage

// File: rtl/mini_proc_if.sv
// mini_proc_if: command issue / completion bus of the mini processor
interface mini_proc_if #(parameter int DW = 16, parameter int NREG = 32);
  localparam int AW = $clog2(NREG);
  logic          start;
  logic [2:0]    cmd;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] imm;
  logic          busy, done, ovf;
  logic [DW-1:0] rdata1, rdata2, result;
  modport master (output start, cmd, rs1, rs2, rd, imm, input busy, done, rdata1, rdata2, result, ovf);
  modport slave (input start, cmd, rs1, rs2, rd, imm, output busy, done, rdata1, rdata2, result, ovf);
endinterface

// File: rtl/mp_regfile.sv
// mp_regfile: NREG x DW register file, two async reads, one sync write
module mp_regfile #(
  parameter int DW = 16,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);
  logic [DW-1:0] mem [NREG];
  // storage: cleared on reset, written on we
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we) mem[wa] <= wd;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/mini_proc_core.sv
// mini_proc_core: 3-stage command processor over an internal register file
module mini_proc_core
  import mini_proc_pkg::*;
#(
  parameter int DW = 16,
  parameter int NREG = 32,
  parameter int SAT_EN = 0
) (
  input logic clk,
  input logic rst,
  mini_proc_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DW);
  localparam logic [DW-1:0] SMAX = DW'(sat_max(DW));
  localparam logic [DW-1:0] SMIN = DW'(sat_min(DW));
  state_e state, nxt;
  cmd_e c_cmd;
  logic [AW-1:0] c_rs1, c_rs2, c_rd;
  logic [DW-1:0] c_imm, op1, op2, rf1, rf2, res, alu, shl, back, sra;
  logic [DW:0] sum;
  logic res_ovf, alu_ovf, aovf, arith, accept, we;
  assign accept = bus.start && (state == IDLE || state == WB);
  assign we = state == WB && c_cmd != CMD_RD1 && c_cmd != CMD_RD2;
  mp_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst), .we(we), .wa(c_rd), .wd(res),
    .ra1(c_rs1), .ra2(c_rs2), .rd1(rf1), .rd2(rf2)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: fixed READ->EXEC->WB walk, re-entering READ on a new accept
  always_comb nxt = state == READ ? EXEC : state == EXEC ? WB : accept ? READ : IDLE;
  // ALU: arithmetic at DW+1 bits so the sign mismatch exposes overflow
  always_comb begin
    sum = c_cmd == CMD_ADDI ? {op1[DW-1], op1} + {c_imm[DW-1], c_imm}
        : c_cmd == CMD_SUB  ? {op1[DW-1], op1} - {op2[DW-1], op2}
        :                     {op1[DW-1], op1} + {op2[DW-1], op2};
    aovf = sum[DW] ^ sum[DW-1];
    arith = c_cmd == CMD_ADDI || c_cmd == CMD_ADD || c_cmd == CMD_SUB;
    shl = op1 << op2[SW-1:0];
    back = $signed(shl) >>> op2[SW-1:0];
    sra = $signed(op1) >>> c_imm[SW-1:0];
    alu = c_cmd == CMD_LDI  ? c_imm
        : arith             ? ((SAT_EN != 0 && aovf) ? (sum[DW] ? SMIN : SMAX) : sum[DW-1:0])
        : c_cmd == CMD_SLLV ? shl
        : c_cmd == CMD_SRAI ? sra
        :                     '0;
    alu_ovf = arith ? aovf : c_cmd == CMD_SLLV ? back != op1 : 1'b0;
  end
  // datapath: latch command, operands, result, then publish on write-back
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c_cmd <= CMD_LDI;
      {c_rs1, c_rs2, c_rd, c_imm, op1, op2, res, res_ovf} <= '0;
      {bus.busy, bus.done, bus.ovf, bus.rdata1, bus.rdata2, bus.result} <= '0;
    end else begin
      if (accept) begin
        c_cmd <= cmd_e'(bus.cmd);
        c_rs1 <= bus.rs1;
        c_rs2 <= bus.rs2;
        c_rd <= bus.rd;
        c_imm <= bus.imm;
      end
      if (state == READ) begin
        op1 <= rf1;
        op2 <= rf2;
      end
      if (state == EXEC) begin
        res <= alu;
        res_ovf <= alu_ovf;
      end
      if (state == WB) begin
        bus.rdata1 <= op1;
        bus.rdata2 <= op2;
        bus.result <= res;
        bus.ovf <= res_ovf;
      end
      bus.done <= state == WB;
      bus.busy <= accept ? 1'b1 : state == WB ? 1'b0 : bus.busy;
    end
endmodule
